// File: rtl/sfu_lane_sequencer_pkg.sv
// Shared types and sizes for the SFU lane sequencer: widths, FSM states,
// lane mask/index types and the latched instruction control payload.
package sfu_seq_pkg;

  localparam int unsigned SFU_WIDTH  = 24;
  localparam int unsigned LANES_C    = 4;
  localparam int unsigned DEST_W     = 5;
  localparam int unsigned OP_W       = 3;
  localparam int unsigned LANE_IDX_W = $clog2(LANES_C);

  typedef logic [LANES_C-1:0]    lane_onehot_t;
  typedef logic [LANE_IDX_W-1:0] lane_idx_t;
  typedef logic [SFU_WIDTH-1:0]  sfu_word_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } sfu_seq_state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DEST_W-1:0] dest;
    logic              bank;
  } sfu_instr_ctrl_t;

  function automatic lane_onehot_t lane_onehot(input lane_idx_t idx);
    return lane_onehot_t'(1) << idx;
  endfunction

endpackage

// File: rtl/sfu_lane_sequencer_if.sv
// Request, SFU issue/result and lane writeback signals of the sequencer.
// The sequencer uses the slave view; the driving environment uses master.
interface sfu_lane_sequencer_if;
  import sfu_seq_pkg::*;

  logic                         req_valid_i;
  logic                         req_ready_o;
  logic [LANES_C*SFU_WIDTH-1:0] req_operands_i;
  logic [OP_W-1:0]              req_op_i;
  logic [DEST_W-1:0]            req_dest_i;
  logic                         req_bank_i;
  lane_onehot_t                 req_mask_i;
  logic                         flush_i;
  logic                         sfu_valid_o;
  sfu_word_t                    sfu_core_operand_o;
  logic [OP_W-1:0]              sfu_core_special_op_o;
  sfu_word_t                    sfu_core_result_i;
  logic                         sfu_core_valid_i;
  lane_onehot_t                 wb_valid_o;
  sfu_word_t                    wb_data_o;
  logic [DEST_W-1:0]            wb_dest_o;
  logic                         wb_bank_o;
  logic                         busy_o;
  logic                         done_o;

  modport slave (
    input  req_valid_i, req_operands_i, req_op_i, req_dest_i, req_bank_i,
           req_mask_i, flush_i, sfu_core_result_i, sfu_core_valid_i,
    output req_ready_o, sfu_valid_o, sfu_core_operand_o, sfu_core_special_op_o,
           wb_valid_o, wb_data_o, wb_dest_o, wb_bank_o, busy_o, done_o
  );

  modport master (
    output req_valid_i, req_operands_i, req_op_i, req_dest_i, req_bank_i,
           req_mask_i, flush_i, sfu_core_result_i, sfu_core_valid_i,
    input  req_ready_o, sfu_valid_o, sfu_core_operand_o, sfu_core_special_op_o,
           wb_valid_o, wb_data_o, wb_dest_o, wb_bank_o, busy_o, done_o
  );

endinterface

// File: rtl/sfu_lane_sequencer_lane_pick.sv
// Lowest-set-bit priority encoder over a lane mask.
module lane_pick
  import sfu_seq_pkg::*;
(
  input  lane_onehot_t mask_i,
  output lane_idx_t    idx_o,
  output logic         any_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    any_o = |mask_i;
    for (int n = LANES_C - 1; n >= 0; n--) begin
      if (mask_i[n]) idx_o = LANE_IDX_W'(n);
    end
  end

endmodule

// File: rtl/sfu_lane_sequencer.sv
// Serialises one SFU instruction over the active SEU lanes through a single
// shared SFU, writing each lane's result back and draining on flush.
module sfu_lane_sequencer
  import sfu_seq_pkg::*;
(
  input logic           clk_i,
  input logic           rst_i,
  sfu_lane_sequencer_if.slave bus
);

  sfu_seq_state_t  state_q, state_d;
  sfu_word_t       operands_q [LANES_C];
  sfu_word_t       operands_d [LANES_C];
  sfu_word_t       req_lanes  [LANES_C];
  sfu_instr_ctrl_t ctrl_q, ctrl_d;
  lane_onehot_t    mask_q, mask_d, pick_mask;
  lane_idx_t       ptr_q, ptr_d, pick_idx;
  logic            pick_any;
  sfu_word_t       operand_q, operand_d;
  lane_onehot_t    wb_valid_q, wb_valid_d;
  sfu_word_t       wb_data_q, wb_data_d;
  logic [DEST_W-1:0] wb_dest_q, wb_dest_d;
  logic            wb_bank_q, wb_bank_d;
  logic            done_q, done_d;
  logic            accept, advance;

  always_comb begin
    for (int n = 0; n < LANES_C; n++) begin
      req_lanes[n] = bus.req_operands_i[n*SFU_WIDTH +: SFU_WIDTH];
    end
  end

  assign accept  = (state_q == IDLE) && bus.req_valid_i && !bus.flush_i;
  assign advance = (state_q == WAIT) && bus.sfu_core_valid_i && !bus.flush_i;

  // One encoder serves both the incoming mask and the remaining working mask.
  assign pick_mask = (state_q == IDLE) ? bus.req_mask_i
                                       : (mask_q & ~lane_onehot(ptr_q));

  lane_pick u_lane_pick (
    .mask_i (pick_mask),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = pick_any ? ISSUE : DONE;
      ISSUE:   state_d = bus.flush_i ? DRAIN : WAIT;
      WAIT: begin
        if (bus.flush_i)           state_d = bus.sfu_core_valid_i ? IDLE : DRAIN;
        else if (bus.sfu_core_valid_i) state_d = pick_any ? ISSUE : DONE;
      end
      DONE:    state_d = IDLE;
      DRAIN:   if (bus.sfu_core_valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    operands_d = operands_q;
    ctrl_d     = ctrl_q;
    mask_d     = mask_q;
    ptr_d      = ptr_q;
    operand_d  = operand_q;
    wb_valid_d = '0;
    wb_data_d  = wb_data_q;
    wb_dest_d  = wb_dest_q;
    wb_bank_d  = wb_bank_q;
    done_d     = (state_d == DONE);
    if (accept) begin
      operands_d = req_lanes;
      ctrl_d     = '{op: bus.req_op_i, dest: bus.req_dest_i, bank: bus.req_bank_i};
      mask_d     = bus.req_mask_i;
      ptr_d      = pick_idx;
      operand_d  = req_lanes[pick_idx];
    end
    if (advance) begin
      mask_d     = pick_mask;
      ptr_d      = pick_idx;
      operand_d  = operands_q[pick_idx];
      wb_valid_d = lane_onehot(ptr_q);
      wb_data_d  = bus.sfu_core_result_i;
      wb_dest_d  = ctrl_q.dest;
      wb_bank_d  = ctrl_q.bank;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int n = 0; n < LANES_C; n++) operands_q[n] <= '0;
      ctrl_q     <= '0;
      mask_q     <= '0;
      ptr_q      <= '0;
      operand_q  <= '0;
      wb_valid_q <= '0;
      wb_data_q  <= '0;
      wb_dest_q  <= '0;
      wb_bank_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      operands_q <= operands_d;
      ctrl_q     <= ctrl_d;
      mask_q     <= mask_d;
      ptr_q      <= ptr_d;
      operand_q  <= operand_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_dest_q  <= wb_dest_d;
      wb_bank_q  <= wb_bank_d;
      done_q     <= done_d;
    end
  end

  assign bus.req_ready_o           = (state_q == IDLE);
  assign bus.busy_o                = (state_q != IDLE);
  assign bus.sfu_valid_o           = (state_q == ISSUE);
  assign bus.sfu_core_operand_o    = operand_q;
  assign bus.sfu_core_special_op_o = ctrl_q.op;
  assign bus.wb_valid_o            = wb_valid_q;
  assign bus.wb_data_o             = wb_data_q;
  assign bus.wb_dest_o             = wb_dest_q;
  assign bus.wb_bank_o             = wb_bank_q;
  assign bus.done_o                = done_q;

endmodule

// File: tb/tb_sfu_lane_sequencer.sv
// Self-checking bench for sfu_lane_sequencer: expected timelines come from
// the latency rules (issue/writeback/done cycles), with a reactive SFU model.
module tb_sfu_lane_sequencer;
  import sfu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sfu_lane_sequencer_if bus();

  sfu_lane_sequencer dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int        n_tests = 0;
  int        n_fail  = 0;
  int        cyc     = 0;
  int        issue_cnt = 0;
  int        sfu_lat = 1;
  bit        sfu_pend = 1'b0;
  int        sfu_due = 0;
  logic [23:0] sfu_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; the SFU answers operand+100 exactly sfu_lat cycles after issue.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    bus.sfu_core_valid_i  = 1'b0;
    bus.sfu_core_result_i = 24'($urandom);
    if (sfu_pend && cyc == sfu_due) begin
      bus.sfu_core_valid_i  = 1'b1;
      bus.sfu_core_result_i = sfu_data;
      sfu_pend = 1'b0;
    end
    if (bus.sfu_valid_o) begin
      issue_cnt++;
      sfu_pend = 1'b1;
      sfu_due  = cyc + sfu_lat;
      sfu_data = bus.sfu_core_operand_o + 24'd100;
    end
  endtask

  task automatic drive_req(input logic [3:0] mask, input logic [95:0] ops,
                           input logic [2:0] op, input logic [4:0] dest, input logic bank);
    bus.req_valid_i    = 1'b1;
    bus.req_mask_i     = mask;
    bus.req_operands_i = ops;
    bus.req_op_i       = op;
    bus.req_dest_i     = dest;
    bus.req_bank_i     = bank;
  endtask

  task automatic scramble_req();
    bus.req_valid_i    = 1'b0;
    bus.req_mask_i     = 4'($urandom);
    bus.req_operands_i = {$urandom, $urandom, $urandom};
    bus.req_op_i       = 3'($urandom);
    bus.req_dest_i     = 5'($urandom);
    bus.req_bank_i     = 1'($urandom);
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, " req_ready"}, 32'(bus.req_ready_o), 32'd1);
    chk({pfx, " busy"},      32'(bus.busy_o), 32'd0);
    chk({pfx, " sfu_valid"}, 32'(bus.sfu_valid_o), 32'd0);
    chk({pfx, " operand"},   32'(bus.sfu_core_operand_o), 32'd0);
    chk({pfx, " sfu_op"},    32'(bus.sfu_core_special_op_o), 32'd0);
    chk({pfx, " wb_valid"},  32'(bus.wb_valid_o), 32'd0);
    chk({pfx, " wb_data"},   32'(bus.wb_data_o), 32'd0);
    chk({pfx, " wb_dest"},   32'(bus.wb_dest_o), 32'd0);
    chk({pfx, " wb_bank"},   32'(bus.wb_bank_o), 32'd0);
    chk({pfx, " done"},      32'(bus.done_o), 32'd0);
  endtask

  // Unflushed instruction: lane j of k issues at 1+j(L+1), writes back L+1 later.
  task automatic run_instr(input string tag, input logic [3:0] mask, input int lat,
                           input logic [95:0] ops, input logic [2:0] op,
                           input logic [4:0] dest, input logic bank);
    logic [3:0]  exp_wb   [64];
    logic [23:0] exp_wd   [64];
    bit          exp_iss  [64];
    logic [23:0] exp_opnd [64];
    int k, ic, done_c, last, iss0;
    for (int c = 0; c < 64; c++) begin
      exp_wb[c] = '0; exp_wd[c] = '0; exp_iss[c] = 1'b0; exp_opnd[c] = '0;
    end
    k = 0;
    for (int ln = 0; ln < 4; ln++) begin
      if (mask[ln]) begin
        ic = 1 + k * (lat + 1);
        exp_iss[ic]          = 1'b1;
        exp_opnd[ic]         = ops[ln*24 +: 24];
        exp_wb[ic + lat + 1] = 4'(1 << ln);
        exp_wd[ic + lat + 1] = ops[ln*24 +: 24] + 24'd100;
        k++;
      end
    end
    done_c = 1 + k * (lat + 1);
    last   = done_c + 1;
    sfu_lat = lat;
    iss0 = issue_cnt;
    drive_req(mask, ops, op, dest, bank);
    for (int c = 0; c <= last; c++) begin
      if (c == 1) scramble_req();
      chk($sformatf("%s ready c%0d", tag, c), 32'(bus.req_ready_o), 32'(c == 0 || c == last));
      chk($sformatf("%s busy c%0d", tag, c), 32'(bus.busy_o), 32'(!(c == 0 || c == last)));
      chk($sformatf("%s sfu_valid c%0d", tag, c), 32'(bus.sfu_valid_o), 32'(exp_iss[c]));
      if (exp_iss[c]) begin
        chk($sformatf("%s operand c%0d", tag, c), 32'(bus.sfu_core_operand_o), 32'(exp_opnd[c]));
        chk($sformatf("%s sfu_op c%0d", tag, c), 32'(bus.sfu_core_special_op_o), 32'(op));
      end
      chk($sformatf("%s wb_valid c%0d", tag, c), 32'(bus.wb_valid_o), 32'(exp_wb[c]));
      if (exp_wb[c] != 4'd0) begin
        chk($sformatf("%s wb_data c%0d", tag, c), 32'(bus.wb_data_o), 32'(exp_wd[c]));
        chk($sformatf("%s wb_dest c%0d", tag, c), 32'(bus.wb_dest_o), 32'(dest));
        chk($sformatf("%s wb_bank c%0d", tag, c), 32'(bus.wb_bank_o), 32'(bank));
      end
      chk($sformatf("%s done c%0d", tag, c), 32'(bus.done_o), 32'(c == done_c));
      step();
    end
    chk({tag, " issue count"}, 32'(issue_cnt - iss0), 32'(k));
  endtask

  // Directed flush scenario: expectations given as explicit cycle numbers (-1 = never).
  task automatic run_flush(input string tag, input logic [3:0] mask, input int lat,
                           input int flush_c, input int ready_c, input int iss_a,
                           input int iss_b, input int wb_c, input logic [3:0] wb_v,
                           input int done_c, input int ncyc);
    logic [95:0] ops;
    bit rdy;
    ops = {$urandom, $urandom, $urandom};
    sfu_lat = lat;
    drive_req(mask, ops, 3'($urandom), 5'($urandom), 1'($urandom));
    for (int c = 0; c < ncyc; c++) begin
      if (c == 1) scramble_req();
      bus.flush_i = (c == flush_c);
      rdy = (c == 0) || (c >= ready_c);
      chk($sformatf("%s ready c%0d", tag, c), 32'(bus.req_ready_o), 32'(rdy));
      chk($sformatf("%s busy c%0d", tag, c), 32'(bus.busy_o), 32'(!rdy));
      chk($sformatf("%s sfu_valid c%0d", tag, c), 32'(bus.sfu_valid_o), 32'(c == iss_a || c == iss_b));
      chk($sformatf("%s wb_valid c%0d", tag, c), 32'(bus.wb_valid_o), 32'((c == wb_c) ? wb_v : 4'd0));
      chk($sformatf("%s done c%0d", tag, c), 32'(bus.done_o), 32'(c == done_c));
      step();
    end
    bus.flush_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    scramble_req();
    bus.flush_i           = 1'b0;
    bus.sfu_core_valid_i  = 1'b0;
    bus.sfu_core_result_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;
    step();

    // Directed latency cases.
    run_instr("m1111", 4'b1111, 1, {24'd4, 24'd3, 24'd2, 24'd1}, 3'd5, 5'd17, 1'b1);
    run_instr("m1010", 4'b1010, 3, {$urandom, $urandom, $urandom}, 3'd2, 5'd9, 1'b0);
    run_instr("m0000", 4'b0000, 2, {$urandom, $urandom, $urandom}, 3'd1, 5'd3, 1'b1);

    // Flush scenarios, each followed by a normal instruction.
    run_flush("fl_wait", 4'b0011, 3, 6, 9, 1, 5, 5, 4'b0001, -1, 11);
    run_instr("after_wait", 4'b0101, 2, {$urandom, $urandom, $urandom}, 3'd6, 5'd21, 1'b0);
    run_flush("fl_coinc", 4'b0110, 2, 3, 4, 1, -1, -1, 4'b0000, -1, 6);
    run_instr("after_coinc", 4'b1001, 1, {$urandom, $urandom, $urandom}, 3'd7, 5'd30, 1'b1);
    run_flush("fl_issue", 4'b1000, 2, 1, 4, 1, -1, -1, 4'b0000, -1, 6);
    run_flush("fl_done", 4'b0001, 1, 3, 4, 1, -1, 3, 4'b0001, 3, 5);
    run_flush("fl_idle", 4'b1111, 1, 0, 0, -1, -1, -1, 4'b0000, -1, 4);

    // Randomised instructions.
    for (int t = 0; t < 12; t++) begin
      run_instr($sformatf("rnd%0d", t), 4'($urandom), int'($urandom_range(1, 4)),
                {$urandom, $urandom, $urandom}, 3'($urandom), 5'($urandom), 1'($urandom));
    end

    // Asynchronous reset in WAIT, then a stray SFU result.
    sfu_lat = 3;
    drive_req(4'b1111, {$urandom, $urandom, $urandom}, 3'd4, 5'd12, 1'b1);
    step();
    scramble_req();
    step();
    step();
    chk("rst pre busy", 32'(bus.busy_o), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    sfu_pend = 1'b0;
    step();
    rst = 1'b0;
    bus.sfu_core_valid_i  = 1'b1;
    bus.sfu_core_result_i = 24'($urandom);
    step();
    check_reset_outputs("stray1");
    step();
    check_reset_outputs("stray2");
    run_instr("after_rst", 4'b0110, 1, {$urandom, $urandom, $urandom}, 3'd3, 5'd8, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sfu_lane_sequencer.md
# sfu_lane_sequencer

Serialises one special-function (SFU) instruction across the four SEU register-file lanes of the fragment core, sharing the single `sfu_core` datapath between them. The control unit hands over a whole instruction (four lane operands plus a lane mask) in one handshake; the sequencer issues each active lane to the SFU in turn, waits for each result, writes it back to that lane, and signals completion so dispatch can resume. It also handles flush: any SFU operation already in flight is drained before new work is accepted.

## Interface
- `SFU_WIDTH`, 24: SFU operand/result width.
- `LANES`, 4: number of SEU lanes.
- `DEST_W`, 5: destination register index width.

- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in 1: instruction offered.
- `req_ready_o` out 1: sequencer can accept. Asserted only in IDLE.
- `req_operands_i` in LANES*SFU_WIDTH: lane operands. Lane n is `[n*SFU_WIDTH +: SFU_WIDTH]`.
- `req_op_i` in 3: SFU special op.
- `req_dest_i` in DEST_W: destination register.
- `req_bank_i` in 1: register bank.
- `req_mask_i` in LANES: active lanes.
- `flush_i` in 1: abort the current instruction.
- `sfu_valid_o` out 1: issue strobe to the SFU.
- `sfu_core_operand_o` out 24: operand of the current lane.
- `sfu_core_special_op_o` out 3: latched op.
- `sfu_core_result_i` in 24: SFU result.
- `sfu_core_valid_i` in 1: SFU result valid.
- `wb_valid_o` out LANES: one-hot lane writeback strobe.
- `wb_data_o` out SFU_WIDTH: writeback data.
- `wb_dest_o` out DEST_W: writeback register.
- `wb_bank_o` out 1: writeback bank.
- `busy_o` out 1: state is not IDLE.
- `done_o` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- **IDLE**
  - On `req_valid_i`, latch operands, op, dest, bank and mask.
  - Lane pointer = lowest set mask bit.
  - Mask == 0 → DONE. Otherwise → ISSUE.
- **ISSUE**
  - `sfu_valid_o` = 1 for exactly one cycle.
  - Operand = latched lane[pointer].
  - → WAIT.
- **WAIT**
  - Hold until `sfu_core_valid_i`, then register the result into the `wb_*` outputs.
  - `wb_valid_o` = one-hot of the pointer on the following cycle, for one cycle.
  - Clear the pointer bit from the working mask.
  - If another bit is set, pointer = next-lowest set bit and → ISSUE. Otherwise → DONE.
- **DONE**
  - `done_o` = 1 for one cycle.
  - → IDLE.
- **DRAIN**
  - Wait for `sfu_core_valid_i`.
  - Discard the result (no `wb_valid_o`), then → IDLE.
- **Flush (`flush_i`)** has priority over normal transitions:
  - IDLE: no effect; a request offered in the same cycle is not accepted.
  - ISSUE: the issue still occurs that cycle; → DRAIN.
  - WAIT without `sfu_core_valid_i`: → DRAIN.
  - WAIT with `sfu_core_valid_i` in the same cycle: result dropped, no writeback; → IDLE.
  - DONE: `done_o` still pulses; → IDLE.
  - DRAIN: no effect.
- `sfu_core_valid_i` outside WAIT and DRAIN is ignored.
- SFU contract: at most one outstanding operation; result latency ≥ 1 cycle after `sfu_valid_o`.

## Timing
- **Reset values:** state IDLE; `req_ready_o` = 1; all other outputs 0 (`sfu_*`, `wb_*`, `busy_o`, `done_o`). Latched registers are cleared.
- **Reset mid-operation:** sequencer returns to IDLE immediately. A later stray SFU result is ignored. The SFU must be reset together with the sequencer.
- **Outputs:** all registered except `req_ready_o`, `busy_o` and `sfu_valid_o`, which decode state directly.
- **Latency, with SFU latency L and k active lanes:**
  - Accept at cycle 0; first ISSUE at cycle 1.
  - Each lane takes L+1 cycles.
  - Writeback of lane i appears in the same cycle as the ISSUE of lane i+1.
  - `done_o` at cycle 1 + k(L+1); `req_ready_o` at 2 + k(L+1).
  - Mask 0: `done_o` at cycle 1.
- Back-to-back instructions: minimum gap of one IDLE cycle.

## Structure
- Package `sfu_seq_pkg`:
  - `sfu_seq_state_t` enum (IDLE, ISSUE, WAIT, DONE, DRAIN).
  - `LANES_C`.
  - `lane_onehot_t` typedef.
- Sub-module `lane_pick`: combinational lowest-set-bit priority encoder over a LANES-bit mask, outputting index and any-set. Used both at accept and at advance.
- Top level contains the FSM, latched operand array, and writeback registers.

## Test plan
- Mask 4'b1111, operands 1,2,3,4, L=1, SFU returns operand+100:
  - `wb_valid_o` = 0001, 0010, 0100, 1000 with data 101, 102, 103, 104 at cycles 3, 5, 7, 9.
  - `done_o` at cycle 9.
- Mask 4'b1010, L=3:
  - Only lanes 1 and 3 are issued; 2 `sfu_valid_o` pulses.
  - `done_o` at cycle 9.
  - Lanes 0 and 2 never strobed.
- Mask 4'b0000:
  - No SFU issue; `done_o` at cycle 1; `req_ready_o` at cycle 2.
- Flush in WAIT of lane 1, result arrives 2 cycles later:
  - State goes to DRAIN; no `wb_valid_o` for lane 1; `busy_o` drops after the result.
  - The next request is accepted and runs correctly.
- Flush coincident with `sfu_core_valid_i`:
  - No writeback; IDLE on the next cycle.
- Assert `rst_i` asynchronously mid-WAIT, then deliver a stray `sfu_core_valid_i`:
  - All outputs return to reset values at once.
  - The stray result produces no writeback.
